// File: rtl/memoria_pkg.sv
// ============================================================================
// Module      : memoria_pkg
// Description : Shared types and constants for the memoria_resp responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package memoria_pkg;

    localparam int          LAT_W    = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Source of the read-data output between reads.
    typedef enum logic [1:0] {
        RD_ZERO  = 2'd0,
        RD_ARRAY = 2'd1,
        RD_ERR   = 2'd2
    } rsel_e;

endpackage

`default_nettype wire

// File: rtl/memoria_array.sv
// ============================================================================
// Module      : memoria_array
// Description : DEPTH x 32 word storage, synchronous write, registered read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module memoria_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge Clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/memoria_resp.sv
// ============================================================================
// Module      : memoria_resp
// Description : Wait-state memory responder; optional MEMORIA_ERR_EN adds
//               misaligned / out-of-range access errors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module memoria_resp
    import memoria_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWr,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        Busy,
    output logic        Err
);

    localparam int               AW     = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    rsel_e             rsel_q, rsel_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, err_q;
    logic [AW-1:0]     idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       arr_rdata;
    logic              accept, access, req_err, arr_we, arr_re;

`ifdef MEMORIA_ERR_EN
    assign req_err = (ReqAddr[1:0] != 2'b00) || (ReqAddr[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign req_err          = 1'b0;
    assign unused_addr_bits = ^{ReqAddr[31:AW+2], ReqAddr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsel_d  = rsel_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                    if (!wr_q) begin
                        rsel_d = err_q ? RD_ERR : RD_ARRAY;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rsel_q  <= RD_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
            if (accept) begin
                err_q <= req_err;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            wr_q    <= ReqWr;
            idx_q   <= ReqAddr[AW+1:2];
            wdata_q <= ReqWData;
        end
    end

    // Storage strobes are gated by Reset so a reset on the access edge drops the access.
    assign arr_we = access && Reset && wr_q && !err_q;
    assign arr_re = access && Reset && !wr_q && !err_q;

    memoria_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .Clock (Clock),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        RespRData = '0;
        case (rsel_q)
            RD_ARRAY: RespRData = arr_rdata;
            RD_ERR:   RespRData = ERR_DATA;
            default:  RespRData = '0;
        endcase
    end

    assign ReqReady  = Reset && (state_q == IDLE);
    assign Busy      = (state_q != IDLE);
    assign RespValid = (state_q == RESP);
`ifdef MEMORIA_ERR_EN
    assign Err       = RespValid && err_q;
`else
    assign Err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memoria_resp.sv
// ============================================================================
// Module      : tb_memoria_resp
// Description : Self-checking bench for memoria_resp (LATENCY 2 and 1 instances).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_memoria_resp;
    import memoria_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_wr     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        busy       [2];
    logic        err        [2];

    memoria_resp #(.DEPTH(256), .LATENCY(2)) dut (
        .Clock(clk), .Reset(rst_n[0]), .ReqValid(req_valid[0]), .ReqWr(req_wr[0]),
        .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]), .ReqReady(req_ready[0]),
        .RespValid(resp_valid[0]), .RespRData(resp_rdata[0]), .Busy(busy[0]), .Err(err[0])
    );

    memoria_resp #(.DEPTH(256), .LATENCY(1)) dut1 (
        .Clock(clk), .Reset(rst_n[1]), .ReqValid(req_valid[1]), .ReqWr(req_wr[1]),
        .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]), .ReqReady(req_ready[1]),
        .RespValid(resp_valid[1]), .RespRData(resp_rdata[1]), .Busy(busy[1]), .Err(err[1])
    );

    // Reference model: word array per instance, plus the value RespRData should hold.
    logic [31:0] mem_m   [2][256];
    bit          known   [2][256];
    logic [31:0] last_rd [2];
    int          lat     [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
`ifdef MEMORIA_ERR_EN
        return (a[1:0] != 2'b00) || (a >= 32'd1024);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd255);
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", req_ready[d], 1);
    endtask

    task automatic drive_req(input int d, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, output bit e);
        int ix;
        req_valid[d] = 1'b1; req_wr[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
        e  = addr_err(a);
        ix = idx_of(a);
        if (wr) begin
            if (!e) begin
                mem_m[d][ix] = wd;
                known[d][ix] = 1'b1;
            end
        end else begin
            last_rd[d] = e ? ERR_DATA : mem_m[d][ix];
        end
    endtask

    task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int n;
        bit e;
        @(negedge clk);
        wait_ready(d);
        drive_req(d, wr, a, wd, e);
        @(negedge clk);
        // Junk on the request bus while busy must be ignored.
        req_valid[d] = 1'b0; req_wr[d] = $urandom_range(0, 1);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        n = 1;
        while (!resp_valid[d] && n < 20) begin
            chk("busy_wait", busy[d], 1);
            chk("ready_wait", req_ready[d], 0);
            @(negedge clk);
            n++;
        end
        chk("resp_seen", resp_valid[d], 1);
        chk("latency", n, lat[d] + 1);
        chk("busy_resp", busy[d], 1);
        chk("ready_resp", req_ready[d], 0);
        chk("err", err[d], e);
        chk("rdata", resp_rdata[d], last_rd[d]);
        @(negedge clk);
        chk("resp_pulse_end", resp_valid[d], 0);
        chk("busy_idle", busy[d], 0);
        chk("err_idle", err[d], 0);
    endtask

    task automatic check_reset_cycle(input int d);
        chk("rst_ready", req_ready[d], 0);
        chk("rst_busy", busy[d], 0);
        chk("rst_resp_valid", resp_valid[d], 0);
        chk("rst_err", err[d], 0);
        chk("rst_rdata", resp_rdata[d], 32'h0);
        last_rd[d] = 32'h0;
    endtask

    // Reset asserted k edges after a write is accepted: the write must vanish.
    task automatic reset_mid(input int d, input int k, input logic [31:0] a, input logic [31:0] wd);
        bit saw = 1'b0;
        @(negedge clk);
        wait_ready(d);
        req_valid[d] = 1'b1; req_wr[d] = 1'b1; req_addr[d] = a; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0;
        repeat (k - 1) @(negedge clk);
        rst_n[d] = 1'b0;
        @(negedge clk);
        check_reset_cycle(d);
        rst_n[d] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid[d]) saw = 1'b1;
        end
        chk("no_resp_after_wait_reset", saw, 0);
    endtask

    // Reset during RESP: the write has already been committed.
    task automatic resp_reset(input int d, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        bit e;
        @(negedge clk);
        wait_ready(d);
        drive_req(d, 1'b1, a, wd, e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        while (!resp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rr_resp_seen", resp_valid[d], 1);
        rst_n[d] = 1'b0;
        @(negedge clk);
        check_reset_cycle(d);
        rst_n[d] = 1'b1;
    endtask

    // ReqValid held high with alternating reads of 0x0 / 0x4.
    task automatic stream(input int d, input int nacc);
        logic [31:0] exp_q[$];
        logic [31:0] a;
        int accepts = 0, resps = 0, last_acc = -1;
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = 1'b0; req_addr[d] = 32'h0;
        for (int cyc = 0; cyc < nacc * (lat[d] + 2) + 3; cyc++) begin
            if (resp_valid[d]) begin
                resps++;
                chk("stream_expected_resp", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("stream_rdata", resp_rdata[d], exp_q.pop_front());
            end
            chk("stream_ready_vs_busy", req_ready[d], !busy[d]);
            if (req_ready[d]) begin
                if (accepts < nacc) begin
                    if (last_acc >= 0) chk("stream_interval", cyc - last_acc, lat[d] + 2);
                    last_acc = cyc;
                    a = (accepts % 2 == 0) ? 32'h0 : 32'h4;
                    req_addr[d] = a;
                    exp_q.push_back(mem_m[d][idx_of(a)]);
                    last_rd[d] = mem_m[d][idx_of(a)];
                    accepts++;
                end else begin
                    req_valid[d] = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        chk("stream_accepts", accepts, nacc);
        chk("stream_resps", resps, nacc);
    endtask

    initial begin
        logic [31:0] a;
        bit          wr;
        lat[0] = 2; lat[1] = 1;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wr[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; last_rd[d] = '0;
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_reset_cycle(d);
            rst_n[d] = 1'b1;
        end

        issue(0, 1'b1, 32'h10, 32'h12345678);
        issue(0, 1'b0, 32'h10, 32'h0);
        issue(1, 1'b1, 32'h10, 32'h0BADC0DE);
        issue(1, 1'b0, 32'h10, 32'h0);

        issue(0, 1'b1, 32'h0, 32'h01010101);
        issue(0, 1'b1, 32'h4, 32'h02020202);
        stream(0, 5);
        issue(1, 1'b1, 32'h0, 32'h03030303);
        issue(1, 1'b1, 32'h4, 32'h04040404);
        stream(1, 4);

        issue(0, 1'b1, 32'h20, 32'hAAAA5555);
        reset_mid(0, 1, 32'h20, 32'h0);
        issue(0, 1'b0, 32'h20, 32'h0);
        reset_mid(0, 2, 32'h20, 32'h0);
        issue(0, 1'b0, 32'h20, 32'h0);
        issue(1, 1'b1, 32'h20, 32'h5555AAAA);
        reset_mid(1, 1, 32'h20, 32'h0);
        issue(1, 1'b0, 32'h20, 32'h0);
        resp_reset(0, 32'h24, 32'h5A5A5A5A);
        issue(0, 1'b0, 32'h24, 32'h0);

        issue(0, 1'b1, 32'h0, 32'h11110000);
        issue(0, 1'b1, 32'h400, 32'hCAFEF00D);
        issue(0, 1'b0, 32'h0, 32'h0);
        issue(0, 1'b0, 32'h13, 32'h0);
        issue(0, 1'b0, 32'h10, 32'h0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                a = $urandom_range(0, 2047);
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF800);
                wr = $urandom_range(0, 1);
                if (!wr && !addr_err(a) && !known[d][idx_of(a)]) wr = 1'b1;
                issue(d, wr, a, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
